// File: rtl/pattern_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// The transition table is fully resolved at elaboration; nothing here becomes search logic.
package pattern_pkg;

   localparam int MAX_LEN   = 16;
   localparam int TBL_DEPTH = 2 * MAX_LEN;

   // One table row per (state, input bit): match flag plus the state to move to.
   typedef struct packed {
      logic       hit;
      logic [3:0] nxt;
   } entry_t;

   typedef entry_t [TBL_DEPTH-1:0] tbl_t;

   function automatic int state_width(input int len);
      int w;
      w = $clog2(len);
      return (w < 1) ? 1 : w;
   endfunction

   // Pattern bit at position pos counted from the first bit received (the MSB).
   function automatic logic pat_bit(input logic [15:0] pat, input int len, input int pos);
      return pat[4'(len - 1 - pos)];
   endfunction

   // Row index is {state, bit}. A row holds the longest pattern prefix that is a suffix
   // of (matched prefix + bit), capped below len; a completed match takes the same
   // fallback (the KMP failure value) when overlap is allowed, otherwise restarts.
   function automatic tbl_t build_table(input logic [15:0] pat, input int len,
                                        input bit overlap);
      tbl_t tbl;
      logic bb;
      logic c;
      bit   hit;
      bit   ok;
      int   best;
      int   kmax;
      int   pos;
      tbl = '0;
      for (int s = 0; s < len; s++) begin
         for (int b = 0; b < 2; b++) begin
            bb   = (b == 1);
            hit  = (bb == pat_bit(pat, len, s)) && (s + 1 == len);
            best = 0;
            kmax = (s + 1 < len) ? s + 1 : len - 1;
            for (int k = kmax; k > 0; k--) begin
               ok = 1'b1;
               for (int j = 0; j < k; j++) begin
                  pos = s + 1 - k + j;
                  c   = (pos < s) ? pat_bit(pat, len, pos) : bb;
                  if (c != pat_bit(pat, len, j)) ok = 1'b0;
               end
               if (ok && best == 0) best = k;
            end
            if (hit && !overlap) best = 0;
            tbl[5'(2 * s + b)].hit = hit;
            tbl[5'(2 * s + b)].nxt = 4'(best);
         end
      end
      return tbl;
   endfunction

endpackage

// File: rtl/pattern.sv
// Serial bit-sequence detector: one bit per clk, registered one-cycle pulse on each match.
// Latency: out rises the cycle after the edge that samples the last pattern bit.
module pattern
   import pattern_pkg::*;
#(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
   parameter bit                 OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   generate
      if (PAT_LEN < 2 || PAT_LEN > MAX_LEN) begin : g_bad_len
         $error("pattern: PAT_LEN must be in 2..16");
      end
   endgenerate

   localparam int   SW  = state_width(PAT_LEN);
   localparam tbl_t TBL = build_table(16'(PATTERN), PAT_LEN, OVERLAP);

   logic [SW-1:0] r_state;
   logic          r_out;
   logic [4:0]    w_idx;
   entry_t        w_entry;

   always_comb begin
      w_idx   = 5'({r_state, in});
      w_entry = TBL[w_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= '0;
         r_out   <= 1'b0;
      end else begin
         r_state <= SW'(w_entry.nxt);
         r_out   <= w_entry.hit;
      end
   end

   assign out = r_out;

endmodule

// File: tb/tb_pattern.sv
// Directed and model-checked bench for pattern: 101 overlap, 101 non-overlap, 1101 overlap.
module tb_pattern;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in  = 1'b0;
   logic out_a, out_b, out_c;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_hist;
   int m_cnt_a, m_cnt_b, m_cnt_c;

   always #5 clk = ~clk;

   pattern #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) u_a (
      .clk(clk), .rst(rst), .in(in), .out(out_a));
   pattern #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_b (
      .clk(clk), .rst(rst), .in(in), .out(out_b));
   pattern #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_c (
      .clk(clk), .rst(rst), .in(in), .out(out_c));

   task automatic check(input string tag, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   // Independent reference: shift history plus bits-since-restart counters.
   task automatic model_step(input logic b, output logic ea, output logic eb, output logic ec);
      m_hist = {m_hist[14:0], b};
      m_cnt_a++;
      m_cnt_b++;
      m_cnt_c++;
      ea = (m_cnt_a >= 3) && (m_hist[2:0] == 3'b101);
      eb = (m_cnt_b >= 3) && (m_hist[2:0] == 3'b101);
      ec = (m_cnt_c >= 4) && (m_hist[3:0] == 4'b1101);
      if (eb) m_cnt_b = 0;
   endtask

   // Reset edges: outputs must stay low whatever is on in.
   task automatic apply_reset(input string tag, input int n, input logic [15:0] bits);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0;
         in  = bits[4'(n - 1 - i)];
         @(posedge clk);
         #1;
         check($sformatf("%s_rst%0d_a", tag, i), out_a, 1'b0);
         check($sformatf("%s_rst%0d_b", tag, i), out_b, 1'b0);
         check($sformatf("%s_rst%0d_c", tag, i), out_c, 1'b0);
      end
      m_hist  = '0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_cnt_c = 0;
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      rst = 1'b1;
      in  = b;
      @(posedge clk);
      #1;
   endtask

   // Sequence and expected pulses are written first-bit-first (MSB = first bit).
   task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] ea, input logic [15:0] eb,
                          input logic [15:0] ec);
      logic ma, mb, mc;
      for (int i = 0; i < n; i++) begin
         model_step(bits[4'(n - 1 - i)], ma, mb, mc);
         drive_bit(bits[4'(n - 1 - i)]);
         check($sformatf("%s_b%0d_a", tag, i + 1), out_a, ea[4'(n - 1 - i)]);
         check($sformatf("%s_b%0d_b", tag, i + 1), out_b, eb[4'(n - 1 - i)]);
         check($sformatf("%s_b%0d_c", tag, i + 1), out_c, ec[4'(n - 1 - i)]);
      end
   endtask

   initial begin
      logic b, ma, mb, mc;

      apply_reset("hold", 3, 16'b101);
      check("reset_state_a", out_a, 1'b0);
      run_seq("first", 3, 16'b101, 16'b001, 16'b001, 16'b000);

      apply_reset("r2", 1, 16'b0);
      run_seq("ovl", 5, 16'b10101, 16'b00101, 16'b00100, 16'b00000);

      apply_reset("r3", 1, 16'b0);
      run_seq("seq6", 6, 16'b101101, 16'b001001, 16'b001001, 16'b000001);

      apply_reset("r4", 1, 16'b0);
      run_seq("fb1101", 4, 16'b1101, 16'b0001, 16'b0001, 16'b0001);

      apply_reset("r5", 1, 16'b0);
      run_seq("fb100101", 6, 16'b100101, 16'b000001, 16'b000001, 16'b000000);

      // Partial progress "10" must be discarded by a single reset edge.
      apply_reset("r6", 1, 16'b0);
      run_seq("mid_pre", 2, 16'b10, 16'b00, 16'b00, 16'b00);
      apply_reset("mid", 1, 16'b1);
      run_seq("mid_post", 3, 16'b101, 16'b001, 16'b001, 16'b000);

      apply_reset("r7", 1, 16'b0);
      run_seq("alt", 7, 16'b1101101, 16'b0001001, 16'b0001001, 16'b0001001);

      apply_reset("r8", 1, 16'b0);
      for (int i = 0; i < 1000; i++) begin
         b = 1'($urandom_range(0, 1));
         model_step(b, ma, mb, mc);
         drive_bit(b);
         check($sformatf("rnd%0d_a", i), out_a, ma);
         check($sformatf("rnd%0d_b", i), out_b, mb);
         check($sformatf("rnd%0d_c", i), out_c, mc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
